// File: rtl/rx_bram_packer_if.sv
// ---------------------------------------------------------------------------
// rx_bram_packer_if
// Bundles the byte-stream input, the RAM write port and the frame status /
// acknowledge signals of rx_bram_packer.
//   in_valid_in / in_data_in[7:0] / in_last_in / in_ready_out : byte stream
//   bram_en_out / bram_we_out[3:0] / bram_addr_out[8:0] /
//   bram_wr_d_out[31:0]                                       : RAM write port
//   frame_done_out / frame_len_out[11:0] / frame_err_out /
//   frame_ack_in                                              : frame status
// slave  : view used by the packer itself.
// master : view used by the surrounding logic (producer, RAM, consumer).
// ---------------------------------------------------------------------------
interface rx_bram_packer_if;
    logic        in_valid_in;
    logic [7:0]  in_data_in;
    logic        in_last_in;
    logic        in_ready_out;

    logic        bram_en_out;
    logic [3:0]  bram_we_out;
    logic [8:0]  bram_addr_out;
    logic [31:0] bram_wr_d_out;

    logic        frame_done_out;
    logic [11:0] frame_len_out;
    logic        frame_err_out;
    logic        frame_ack_in;

    modport slave (
        input  in_valid_in, in_data_in, in_last_in, frame_ack_in,
        output in_ready_out, bram_en_out, bram_we_out, bram_addr_out,
               bram_wr_d_out, frame_done_out, frame_len_out, frame_err_out
    );

    modport master (
        output in_valid_in, in_data_in, in_last_in, frame_ack_in,
        input  in_ready_out, bram_en_out, bram_we_out, bram_addr_out,
               bram_wr_d_out, frame_done_out, frame_len_out, frame_err_out
    );
endinterface

// File: rtl/rx_bram_packer.sv
// ---------------------------------------------------------------------------
// rx_bram_packer
// Packs a framed byte stream big-endian into 32-bit words and writes them
// into a 512 x 32 frame buffer through byte write enables. At end of frame
// it reports length / truncation and waits for the consumer's acknowledge.
//   clk_in        : clock (also clocks the RAM write port)
//   rst_n_in      : asynchronous, active-low reset
//   bus (slave)   : stream in, RAM write port out, frame status / ack
//   dbg_state_out : current FSM state (0 RECV, 1 DROP, 2 FLUSH, 3 DONE)
//
// Handshake: a byte moves on a rising edge where in_valid_in and
// in_ready_out are both high; in_valid_in may be raised or dropped at any
// time, in_ready_out never depends combinationally on in_valid_in, and a
// byte offered while in_ready_out is low is simply not taken.
// ---------------------------------------------------------------------------
module rx_bram_packer #(
    parameter int MAX_BYTES = 2048
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    rx_bram_packer_if.slave   bus,
    output logic [1:0]        dbg_state_out
);

    localparam logic [1:0] ST_RECV  = 2'd0;
    localparam logic [1:0] ST_DROP  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [11:0] MAX_K = 12'(MAX_BYTES);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [11:0] byte_idx;
    logic [31:0] asm_word;
    logic [3:0]  asm_mask;

    logic        xfer;
    logic        at_cap;
    logic        word_end;
    logic        ack_ok;
    logic [1:0]  lane_sel;
    logic [31:0] word_merge;
    logic [3:0]  mask_merge;

    assign xfer     = bus.in_valid_in && bus.in_ready_out;
    // Byte index equal to capacity means the buffer is already full.
    assign at_cap   = (byte_idx == MAX_K);
    // lane = 3 - (k mod 4): the first byte of a word goes to [31:24].
    assign lane_sel = ~byte_idx[1:0];
    assign word_end = (byte_idx[1:0] == 2'b11) || bus.in_last_in;
    // The acknowledge only counts once the consumer can see frame_done_out.
    assign ack_ok   = bus.frame_done_out && bus.frame_ack_in;

    assign word_merge = asm_word | ({24'd0, bus.in_data_in} << {lane_sel, 3'b000});
    assign mask_merge = asm_mask | (4'b0001 << lane_sel);

    assign dbg_state_out = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RECV: begin
                if (xfer) begin
                    if (at_cap) begin
                        state_nxt = bus.in_last_in ? ST_FLUSH : ST_DROP;
                    end else if (bus.in_last_in) begin
                        state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_DROP: begin
                if (xfer && bus.in_last_in) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (ack_ok) begin
                    state_nxt = ST_RECV;
                end
            end
            default: begin
                state_nxt = ST_RECV;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state              <= ST_RECV;
            byte_idx           <= 12'd0;
            asm_word           <= 32'd0;
            asm_mask           <= 4'd0;
            bus.in_ready_out   <= 1'b0;
            bus.bram_en_out    <= 1'b0;
            bus.bram_we_out    <= 4'd0;
            bus.bram_addr_out  <= 9'd0;
            bus.bram_wr_d_out  <= 32'd0;
            bus.frame_done_out <= 1'b0;
            bus.frame_len_out  <= 12'd0;
            bus.frame_err_out  <= 1'b0;
        end else begin
            state            <= state_nxt;
            // Ready is registered from the next state so it is low from the
            // edge that takes the last byte and high on the acknowledge edge.
            bus.in_ready_out <= (state_nxt == ST_RECV) || (state_nxt == ST_DROP);
            bus.bram_en_out  <= 1'b0;
            bus.bram_we_out  <= 4'd0;

            case (state)
                ST_RECV: begin
                    if (xfer) begin
                        if (at_cap) begin
                            // Buffer full: byte discarded, the last full word
                            // has already been written.
                            bus.frame_err_out <= 1'b1;
                            bus.frame_len_out <= MAX_K;
                        end else begin
                            byte_idx <= byte_idx + 12'd1;
                            if (word_end) begin
                                // Hand the word to the RAM port and clear the
                                // assembly register so the next byte can land
                                // on this very write cycle.
                                bus.bram_en_out   <= 1'b1;
                                bus.bram_we_out   <= mask_merge;
                                bus.bram_addr_out <= byte_idx[10:2];
                                bus.bram_wr_d_out <= word_merge;
                                asm_word          <= 32'd0;
                                asm_mask          <= 4'd0;
                            end else begin
                                asm_word <= word_merge;
                                asm_mask <= mask_merge;
                            end
                            if (bus.in_last_in) begin
                                bus.frame_len_out <= byte_idx + 12'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (ack_ok) begin
                        bus.frame_done_out <= 1'b0;
                        bus.frame_err_out  <= 1'b0;
                        byte_idx           <= 12'd0;
                    end else begin
                        bus.frame_done_out <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
